nvdla_dbb_initiator: RTL

Single-transaction DBB master that drives the NVDLA data-backbone (DBB) memory interface from the requester side: write request, write data, write response, read request and read data channels. It issues one burst at a time from a command port, takes write beats from an input stream and returns read beats on an output stream. It is the counterpart of the wrapper's DBB responder FSM and exercises that responder, or any DBB slave, standalone in the HWPE subsystem.

---
 rtl/nvdla_dbb_initiator.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/nvdla_dbb_initiator.sv
// -----------------------------------------------------------------------------
// nvdla_dbb_initiator
//
// Single-outstanding-transaction master for the NVDLA data backbone (DBB).
// It takes one command at a time (write or read burst of 1..16 beats). It
// issues the request on the matching DBB channel. Write beats pass from the
// input stream to the DBB write-data channel, and read beats pass from the
// DBB read-data channel to the output stream. Once the burst finishes it
// pulses done_o, with err_o set on any id or burst-length disagreement.
//
// Ports
//   clk_i, rst_ni              clock, synchronous active-low reset
//   cmd_*                      command handshake (write/addr/len/id)
//   wdata_*                    write-beat input stream (data/strb)
//   rdata_*                    read-beat output stream (data/last)
//   dbb_wr_req_*               DBB write request channel
//   dbb_wr_dat_*               DBB write data channel
//   dbb_wr_rsp_*               DBB write response channel
//   dbb_rd_req_*               DBB read request channel
//   dbb_rd_dat_*               DBB read data channel
//   done_o, err_o              end-of-transaction pulse and its error flag
//
// Build option
//   NVDLA_DBB_INIT_TIMEOUT_EN  adds a 16-bit watchdog. If a busy state waits
//                              TIMEOUT_CYCLES cycles with no handshake on its
//                              channel, the watchdog forces DONE with err_o=1.
// -----------------------------------------------------------------------------
module nvdla_dbb_initiator #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [31:0]             cmd_addr_i,
  input  logic [3:0]              cmd_len_i,
  input  logic [7:0]              cmd_id_i,
  input  logic                    wdata_valid_i,
  output logic                    wdata_ready_o,
  input  logic [DATA_WIDTH-1:0]   wdata_data_i,
  input  logic [DATA_WIDTH/8-1:0] wdata_strb_i,
  output logic                    rdata_valid_o,
  input  logic                    rdata_ready_i,
  output logic [DATA_WIDTH-1:0]   rdata_data_o,
  output logic                    rdata_last_o,
  output logic                    dbb_wr_req_valid_o,
  input  logic                    dbb_wr_req_ready_i,
  output logic [31:0]             dbb_wr_req_addr_o,
  output logic [3:0]              dbb_wr_req_len_o,
  output logic [7:0]              dbb_wr_req_id_o,
  output logic                    dbb_wr_dat_valid_o,
  input  logic                    dbb_wr_dat_ready_i,
  output logic [DATA_WIDTH-1:0]   dbb_wr_dat_data_o,
  output logic [DATA_WIDTH/8-1:0] dbb_wr_dat_strb_o,
  output logic                    dbb_wr_dat_last_o,
  input  logic                    dbb_wr_rsp_valid_i,
  output logic                    dbb_wr_rsp_ready_o,
  input  logic [7:0]              dbb_wr_rsp_id_i,
  output logic                    dbb_rd_req_valid_o,
  input  logic                    dbb_rd_req_ready_i,
  output logic [31:0]             dbb_rd_req_addr_o,
  output logic [3:0]              dbb_rd_req_len_o,
  output logic [7:0]              dbb_rd_req_id_o,
  input  logic                    dbb_rd_dat_valid_i,
  output logic                    dbb_rd_dat_ready_o,
  input  logic [DATA_WIDTH-1:0]   dbb_rd_dat_data_i,
  input  logic                    dbb_rd_dat_last_i,
  input  logic [7:0]              dbb_rd_dat_id_i,
  output logic                    done_o,
  output logic                    err_o
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WREQ, ST_WDATA, ST_WRESP, ST_RREQ, ST_RDATA, ST_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  len_q, len_d;
  logic [7:0]  id_q, id_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  // Beats actually transferred in the current state.
  logic wbeat, rbeat, chan_hs, timeout;
  assign wbeat = (state_q == ST_WDATA) && wdata_valid_i && dbb_wr_dat_ready_i;
  assign rbeat = (state_q == ST_RDATA) && dbb_rd_dat_valid_i && rdata_ready_i;
  assign chan_hs = ((state_q == ST_WREQ)  && dbb_wr_req_ready_i) ||
                   ((state_q == ST_RREQ)  && dbb_rd_req_ready_i) ||
                   ((state_q == ST_WRESP) && dbb_wr_rsp_valid_i) ||
                   wbeat || rbeat;

`ifdef NVDLA_DBB_INIT_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic        busy;
  assign busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
  // Counts consecutive stalled cycles; the cycle that would reach the limit
  // is the one that bails out.
  assign wd_d    = (busy && !chan_hs) ? wd_q + 16'd1 : 16'd0;
  assign timeout = busy && !chan_hs && (wd_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) wd_q <= '0;
    else         wd_q <= wd_d;
  end
`else
  // Without the watchdog the limit has no meaning; keep it referenced.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every variable gets a hold/default value first so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: if (cmd_valid_i) begin
        addr_d  = cmd_addr_i;
        len_d   = cmd_len_i;
        id_d    = cmd_id_i;
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = cmd_write_i ? ST_WREQ : ST_RREQ;
      end
      ST_WREQ:  if (dbb_wr_req_ready_i) state_d = ST_WDATA;
      ST_WDATA: if (wbeat) begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == len_q) state_d = ST_WRESP;
      end
      ST_WRESP: if (dbb_wr_rsp_valid_i) begin
        if (dbb_wr_rsp_id_i != id_q) err_d = 1'b1;
        state_d = ST_DONE;
      end
      ST_RREQ:  if (dbb_rd_req_ready_i) state_d = ST_RDATA;
      ST_RDATA: if (rbeat) begin
        cnt_d = cnt_q + 4'd1;
        // Slave's last flag must coincide exactly with the final beat.
        if ((dbb_rd_dat_id_i != id_q) ||
            (dbb_rd_dat_last_i != (cnt_q == len_q))) err_d = 1'b1;
        if (dbb_rd_dat_last_i || (cnt_q == len_q)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (timeout) begin
      state_d = ST_DONE;
      err_d   = 1'b1;
    end
  end

  // Valids are qualified with rst_ni so they fall as soon as reset is asserted
  // rather than at the following edge.
  always_comb begin
    cmd_ready_o        = 1'b0;
    wdata_ready_o      = 1'b0;
    rdata_valid_o      = 1'b0;
    rdata_data_o       = '0;
    rdata_last_o       = 1'b0;
    dbb_wr_req_valid_o = 1'b0;
    dbb_wr_dat_valid_o = 1'b0;
    dbb_wr_dat_data_o  = '0;
    dbb_wr_dat_strb_o  = '0;
    dbb_wr_dat_last_o  = 1'b0;
    dbb_wr_rsp_ready_o = 1'b0;
    dbb_rd_req_valid_o = 1'b0;
    dbb_rd_dat_ready_o = 1'b0;
    done_o             = 1'b0;
    err_o              = 1'b0;
    unique case (state_q)
      ST_IDLE:  cmd_ready_o = 1'b1;
      ST_WREQ:  dbb_wr_req_valid_o = rst_ni;
      ST_WDATA: begin
        dbb_wr_dat_valid_o = wdata_valid_i && rst_ni;
        wdata_ready_o      = dbb_wr_dat_ready_i;
        dbb_wr_dat_data_o  = wdata_data_i;
        dbb_wr_dat_strb_o  = wdata_strb_i;
        dbb_wr_dat_last_o  = (cnt_q == len_q);
      end
      ST_WRESP: dbb_wr_rsp_ready_o = 1'b1;
      ST_RREQ:  dbb_rd_req_valid_o = rst_ni;
      ST_RDATA: begin
        rdata_valid_o      = dbb_rd_dat_valid_i && rst_ni;
        dbb_rd_dat_ready_o = rdata_ready_i;
        rdata_data_o       = dbb_rd_dat_data_i;
        rdata_last_o       = dbb_rd_dat_last_i;
      end
      ST_DONE: begin
        done_o = rst_ni;
        err_o  = err_q && rst_ni;
      end
      default: ;
    endcase
  end

  assign dbb_wr_req_addr_o = addr_q;
  assign dbb_wr_req_len_o  = len_q;
  assign dbb_wr_req_id_o   = id_q;
  assign dbb_rd_req_addr_o = addr_q;
  assign dbb_rd_req_len_o  = len_q;
  assign dbb_rd_req_id_o   = id_q;

endmodule
